// File: rtl/id_ex_stage_reg.sv
// -----------------------------------------------------------------------------
// id_ex_stage_reg
//
// Purpose:
//   Decode -> execute pipeline register with hazard control. Captures the
//   decoded instruction fields (pc, imm, rs1/rs2/rd, write-enable, load flag,
//   2-bit forward control code) and presents them to EX and the downstream
//   forwarding unit one cycle later. Inserts one bubble on a load-use hazard,
//   FLUSH_BUBBLES bubbles on a taken branch/jump, and holds while EX is not
//   ready.
//
// Parameters:
//   XLEN            width of pc / imm
//   FLUSH_BUBBLES   bubbles inserted per flush (legal range 1..7)
//
// Optional feature (macro STALL_COUNTER_EN):
//   When defined, o_bubble_count counts bubbles inserted because of a hazard
//   or a flush (wraps at 2^32). When undefined the port and counter are absent.
//
// Ports:
//   clk              in   rising-edge clock
//   rst_n            in   synchronous active-low reset
//   i_id_*           in   decode-stage instruction fields
//   i_flush          in   branch/jump taken in EX
//   i_ex_ready       in   EX accepts a new instruction this cycle
//   o_stall_id       out  combinational: hold fetch/decode this cycle
//   o_ex_*           out  registered instruction fields presented to EX
//   o_bubble_count   out  bubble counter (STALL_COUNTER_EN only)
// -----------------------------------------------------------------------------
module id_ex_stage_reg #(
  parameter int XLEN          = 32,
  parameter int FLUSH_BUBBLES = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_id_valid,
  input  logic [XLEN-1:0] i_id_pc,
  input  logic [XLEN-1:0] i_id_imm,
  input  logic [4:0]      i_id_rs1,
  input  logic [4:0]      i_id_rs2,
  input  logic [4:0]      i_id_rd,
  input  logic            i_id_uses_rs1,
  input  logic            i_id_uses_rs2,
  input  logic            i_id_reg_we,
  input  logic            i_id_is_load,
  input  logic [1:0]      i_id_fwd_ctrl,
  input  logic            i_flush,
  input  logic            i_ex_ready,
  output logic            o_stall_id,
  output logic            o_ex_valid,
  output logic [XLEN-1:0] o_ex_pc,
  output logic [XLEN-1:0] o_ex_imm,
  output logic [4:0]      o_ex_rs1,
  output logic [4:0]      o_ex_rs2,
  output logic [4:0]      o_ex_rd,
  output logic            o_ex_reg_we,
  output logic            o_ex_is_load,
  output logic [1:0]      o_ex_fwd_ctrl
`ifdef STALL_COUNTER_EN
  ,
  output logic [31:0]     o_bubble_count
`endif
);

  typedef enum logic [1:0] {
    ST_RUN        = 2'd0,
    ST_LOAD_STALL = 2'd1,
    ST_FLUSH      = 2'd2
  } state_t;

  // What the pipeline register does on the coming edge.
  typedef enum logic [1:0] {
    ACT_HOLD    = 2'd0,
    ACT_ADVANCE = 2'd1,
    ACT_BUBBLE  = 2'd2
  } act_t;

  localparam logic [2:0] FLUSH_RELOAD = 3'(FLUSH_BUBBLES - 1);
  localparam bit         FLUSH_MULTI  = (FLUSH_BUBBLES > 1);

  state_t          r_state;
  state_t          w_state_next;
  logic [2:0]      r_flush_cnt;
  logic [2:0]      w_flush_cnt_next;
  act_t            w_act;
  logic            w_stall_id;
  logic            w_count_bubble;
  logic            w_hazard;
  logic            w_load;
  logic            w_clear;

  logic            r_ex_valid;
  logic [XLEN-1:0] r_ex_pc;
  logic [XLEN-1:0] r_ex_imm;
  logic [4:0]      r_ex_rs1;
  logic [4:0]      r_ex_rs2;
  logic [4:0]      r_ex_rd;
  logic            r_ex_reg_we;
  logic            r_ex_is_load;
  logic [1:0]      r_ex_fwd_ctrl;

  // Load in EX whose destination is read by the instruction in decode.
  // x0 is never a real dependency.
  assign w_hazard = i_id_valid & r_ex_valid & r_ex_is_load & (r_ex_rd != 5'd0)
                  & ((i_id_uses_rs1 & (i_id_rs1 == r_ex_rd))
                   | (i_id_uses_rs2 & (i_id_rs2 == r_ex_rd)));

  // Priority: flush > back-pressure > hazard > advance (reset is in always_ff).
  always_comb begin
    w_state_next     = r_state;
    w_flush_cnt_next = r_flush_cnt;
    w_act            = ACT_ADVANCE;
    w_stall_id       = 1'b0;
    w_count_bubble   = 1'b0;
    if (i_flush) begin
      // Flush kills the decode slot even if EX is stalled.
      w_act          = ACT_BUBBLE;
      w_count_bubble = 1'b1;
      if (FLUSH_MULTI) begin
        w_state_next     = ST_FLUSH;
        w_flush_cnt_next = FLUSH_RELOAD;
      end else begin
        w_state_next     = ST_RUN;
        w_flush_cnt_next = 3'd0;
      end
    end else if (!i_ex_ready) begin
      w_act      = ACT_HOLD;
      w_stall_id = 1'b1;
    end else begin
      unique case (r_state)
        ST_FLUSH: begin
          // Decode still holds a wrong-path instruction: squash it.
          w_act            = ACT_BUBBLE;
          w_count_bubble   = 1'b1;
          w_flush_cnt_next = r_flush_cnt - 3'd1;
          if (r_flush_cnt <= 3'd1) begin
            w_state_next     = ST_RUN;
            w_flush_cnt_next = 3'd0;
          end
        end
        ST_LOAD_STALL: begin
          // Hazard masked: the bubble already covers the load latency.
          w_act        = ACT_ADVANCE;
          w_state_next = ST_RUN;
        end
        default: begin
          if (w_hazard) begin
            w_act          = ACT_BUBBLE;
            w_stall_id     = 1'b1;
            w_count_bubble = 1'b1;
            w_state_next   = ST_LOAD_STALL;
          end else begin
            w_act        = ACT_ADVANCE;
            w_state_next = ST_RUN;
          end
        end
      endcase
    end
  end

  // An advancing empty decode slot is captured as a clean bubble too.
  assign w_load  = (w_act == ACT_ADVANCE) & i_id_valid;
  assign w_clear = (w_act == ACT_BUBBLE) | ((w_act == ACT_ADVANCE) & ~i_id_valid);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= ST_RUN;
      r_flush_cnt <= 3'd0;
    end else begin
      r_state     <= w_state_next;
      r_flush_cnt <= w_flush_cnt_next;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || w_clear) begin
      r_ex_valid    <= 1'b0;
      r_ex_pc       <= '0;
      r_ex_imm      <= '0;
      r_ex_rs1      <= 5'd0;
      r_ex_rs2      <= 5'd0;
      r_ex_rd       <= 5'd0;
      r_ex_reg_we   <= 1'b0;
      r_ex_is_load  <= 1'b0;
      r_ex_fwd_ctrl <= 2'b00;
    end else if (w_load) begin
      r_ex_valid    <= 1'b1;
      r_ex_pc       <= i_id_pc;
      r_ex_imm      <= i_id_imm;
      r_ex_rs1      <= i_id_rs1;
      r_ex_rs2      <= i_id_rs2;
      r_ex_rd       <= i_id_rd;
      r_ex_reg_we   <= i_id_reg_we;
      r_ex_is_load  <= i_id_is_load;
      r_ex_fwd_ctrl <= i_id_fwd_ctrl;
    end
  end

`ifdef STALL_COUNTER_EN
  logic [31:0] r_bubble_count;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_bubble_count <= 32'd0;
    end else if (w_count_bubble) begin
      r_bubble_count <= r_bubble_count + 32'd1;
    end
  end

  assign o_bubble_count = r_bubble_count;
`endif

  assign o_stall_id    = w_stall_id;
  assign o_ex_valid    = r_ex_valid;
  assign o_ex_pc       = r_ex_pc;
  assign o_ex_imm      = r_ex_imm;
  assign o_ex_rs1      = r_ex_rs1;
  assign o_ex_rs2      = r_ex_rs2;
  assign o_ex_rd       = r_ex_rd;
  assign o_ex_reg_we   = r_ex_reg_we;
  assign o_ex_is_load  = r_ex_is_load;
  assign o_ex_fwd_ctrl = r_ex_fwd_ctrl;

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// -----------------------------------------------------------------------------
// tb_id_ex_stage_reg
//
// Self-checking bench for id_ex_stage_reg (FLUSH_BUBBLES = 2). Each scenario
// task builds a table of per-cycle stimulus with the expected stall_id and
// expected EX-stage contents, pushes the expected EX contents to a scoreboard
// when the cycle is driven and pops/compares them after the clock edge.
// Bubble counter checks are compiled only with STALL_COUNTER_EN.
// -----------------------------------------------------------------------------
module tb_id_ex_stage_reg;

  localparam logic [1:0] FORWARD_NONE = 2'b00;
  localparam logic [1:0] FORWARD_IMM  = 2'b10;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        u1;
    logic        u2;
    logic        we;
    logic        load;
    logic [1:0]  fwd;
  } id_t;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        we;
    logic        load;
    logic [1:0]  fwd;
  } ex_t;

  typedef struct {
    id_t  id;
    logic flush;
    logic ready;
    logic rst_n;
    logic stall;
    ex_t  exp;
  } step_t;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        ex_ready;
  id_t         id_drv;
  logic        stall_id;
  logic        ex_valid;
  logic [31:0] ex_pc;
  logic [31:0] ex_imm;
  logic [4:0]  ex_rs1;
  logic [4:0]  ex_rs2;
  logic [4:0]  ex_rd;
  logic        ex_reg_we;
  logic        ex_is_load;
  logic [1:0]  ex_fwd_ctrl;
`ifdef STALL_COUNTER_EN
  logic [31:0] bubble_count;
`endif
  ex_t         w_got;

  int          n_pass;
  int          n_total;
  int unsigned exp_bubbles;
  ex_t         sb[$];
  step_t       steps[$];
  ex_t         exp_item;

  id_t LW5, ADD, LW0, ADD0, LW7, SUB, LW9, NU, X, Y, P, Q, LWH, H, A, C, IDLE;

  id_ex_stage_reg #(
    .XLEN(32),
    .FLUSH_BUBBLES(2)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .i_id_valid(id_drv.valid),
    .i_id_pc(id_drv.pc),
    .i_id_imm(id_drv.imm),
    .i_id_rs1(id_drv.rs1),
    .i_id_rs2(id_drv.rs2),
    .i_id_rd(id_drv.rd),
    .i_id_uses_rs1(id_drv.u1),
    .i_id_uses_rs2(id_drv.u2),
    .i_id_reg_we(id_drv.we),
    .i_id_is_load(id_drv.load),
    .i_id_fwd_ctrl(id_drv.fwd),
    .i_flush(flush),
    .i_ex_ready(ex_ready),
    .o_stall_id(stall_id),
    .o_ex_valid(ex_valid),
    .o_ex_pc(ex_pc),
    .o_ex_imm(ex_imm),
    .o_ex_rs1(ex_rs1),
    .o_ex_rs2(ex_rs2),
    .o_ex_rd(ex_rd),
    .o_ex_reg_we(ex_reg_we),
    .o_ex_is_load(ex_is_load),
    .o_ex_fwd_ctrl(ex_fwd_ctrl)
`ifdef STALL_COUNTER_EN
    ,
    .o_bubble_count(bubble_count)
`endif
  );

  assign w_got = {ex_valid, ex_pc, ex_imm, ex_rs1, ex_rs2, ex_rd, ex_reg_we, ex_is_load, ex_fwd_ctrl};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic id_t mk(input logic [31:0] pc, input logic [4:0] rs1, input logic [4:0] rs2,
                             input logic [4:0] rd, input logic u1, input logic u2, input logic we,
                             input logic ld, input logic [1:0] fwd);
    id_t d;
    d.valid = 1'b1;
    d.pc    = pc;
    d.imm   = pc ^ 32'h5A5A_0F0F;
    d.rs1   = rs1;
    d.rs2   = rs2;
    d.rd    = rd;
    d.u1    = u1;
    d.u2    = u2;
    d.we    = we;
    d.load  = ld;
    d.fwd   = fwd;
    return d;
  endfunction

  // Expected EX contents one cycle after an instruction advances.
  function automatic ex_t adv(input id_t d);
    ex_t e;
    e = '0;
    if (d.valid) begin
      e.valid = 1'b1;
      e.pc    = d.pc;
      e.imm   = d.imm;
      e.rs1   = d.rs1;
      e.rs2   = d.rs2;
      e.rd    = d.rd;
      e.we    = d.we;
      e.load  = d.load;
      e.fwd   = d.fwd;
    end
    return e;
  endfunction

  function automatic step_t st(input id_t d, input logic fl, input logic rdy, input logic rn,
                               input logic stl, input ex_t e);
    step_t s;
    s.id    = d;
    s.flush = fl;
    s.ready = rdy;
    s.rst_n = rn;
    s.stall = stl;
    s.exp   = e;
    return s;
  endfunction

  task automatic test_reset();
    ex_t bub;
    bub = '0;
    steps.delete();
    steps.push_back(st(A, 1'b0, 1'b1, 1'b0, 1'b0, bub));
    steps.push_back(st(A, 1'b1, 1'b1, 1'b0, 1'b0, bub));
    steps.push_back(st(IDLE, 1'b0, 1'b1, 1'b1, 1'b0, bub));
    foreach (steps[k]) begin
      id_drv = steps[k].id; flush = steps[k].flush; ex_ready = steps[k].ready; rst_n = steps[k].rst_n;
      #1;
      n_total++;
      if (stall_id !== steps[k].stall)
        $display("FAIL reset_stall step=%0d got=%b exp=%b", k, stall_id, steps[k].stall);
      else n_pass++;
      sb.push_back(steps[k].exp);
      @(posedge clk); #1;
      exp_item = sb.pop_front();
      n_total++;
      if (w_got !== exp_item)
        $display("FAIL reset_ex step=%0d got=%h exp=%h", k, w_got, exp_item);
      else n_pass++;
      $display("reset     step %0d: ex_valid=%b pc=%h rd=%0d stall=%b", k, ex_valid, ex_pc, ex_rd, stall_id);
    end
    exp_bubbles = 0;
`ifdef STALL_COUNTER_EN
    n_total++;
    if (bubble_count !== exp_bubbles)
      $display("FAIL reset_bubbles got=%0d exp=%0d", bubble_count, exp_bubbles);
    else n_pass++;
`endif
  endtask

  task automatic test_advance();
    id_t nv;
    nv = mk(32'h180, 5'd3, 5'd4, 5'd9, 1'b1, 1'b1, 1'b1, 1'b1, FORWARD_IMM);
    nv.valid = 1'b0;
    steps.delete();
    steps.push_back(st(A,    1'b0, 1'b1, 1'b1, 1'b0, adv(A)));
    steps.push_back(st(IDLE, 1'b0, 1'b1, 1'b1, 1'b0, adv(IDLE)));
    steps.push_back(st(C,    1'b0, 1'b1, 1'b1, 1'b0, adv(C)));
    steps.push_back(st(nv,   1'b0, 1'b1, 1'b1, 1'b0, ex_t'(0)));
    steps.push_back(st(A,    1'b0, 1'b1, 1'b1, 1'b0, adv(A)));
    foreach (steps[k]) begin
      id_drv = steps[k].id; flush = steps[k].flush; ex_ready = steps[k].ready; rst_n = steps[k].rst_n;
      #1;
      n_total++;
      if (stall_id !== steps[k].stall)
        $display("FAIL advance_stall step=%0d got=%b exp=%b", k, stall_id, steps[k].stall);
      else n_pass++;
      sb.push_back(steps[k].exp);
      @(posedge clk); #1;
      exp_item = sb.pop_front();
      n_total++;
      if (w_got !== exp_item)
        $display("FAIL advance_ex step=%0d got=%h exp=%h", k, w_got, exp_item);
      else n_pass++;
      $display("advance   step %0d: ex_valid=%b pc=%h rd=%0d stall=%b", k, ex_valid, ex_pc, ex_rd, stall_id);
    end
  endtask

  task automatic test_load_use();
    steps.delete();
    steps.push_back(st(LW5,  1'b0, 1'b1, 1'b1, 1'b0, adv(LW5)));
    steps.push_back(st(ADD,  1'b0, 1'b1, 1'b1, 1'b1, ex_t'(0)));
    steps.push_back(st(ADD,  1'b0, 1'b1, 1'b1, 1'b0, adv(ADD)));
    steps.push_back(st(LW0,  1'b0, 1'b1, 1'b1, 1'b0, adv(LW0)));
    steps.push_back(st(ADD0, 1'b0, 1'b1, 1'b1, 1'b0, adv(ADD0)));
    steps.push_back(st(LW7,  1'b0, 1'b1, 1'b1, 1'b0, adv(LW7)));
    steps.push_back(st(SUB,  1'b0, 1'b1, 1'b1, 1'b1, ex_t'(0)));
    steps.push_back(st(SUB,  1'b0, 1'b1, 1'b1, 1'b0, adv(SUB)));
    steps.push_back(st(LW9,  1'b0, 1'b1, 1'b1, 1'b0, adv(LW9)));
    steps.push_back(st(NU,   1'b0, 1'b1, 1'b1, 1'b0, adv(NU)));
    foreach (steps[k]) begin
      id_drv = steps[k].id; flush = steps[k].flush; ex_ready = steps[k].ready; rst_n = steps[k].rst_n;
      #1;
      n_total++;
      if (stall_id !== steps[k].stall)
        $display("FAIL load_use_stall step=%0d got=%b exp=%b", k, stall_id, steps[k].stall);
      else n_pass++;
      sb.push_back(steps[k].exp);
      @(posedge clk); #1;
      exp_item = sb.pop_front();
      n_total++;
      if (w_got !== exp_item)
        $display("FAIL load_use_ex step=%0d got=%h exp=%h", k, w_got, exp_item);
      else n_pass++;
      $display("load_use  step %0d: ex_valid=%b pc=%h rd=%0d stall=%b", k, ex_valid, ex_pc, ex_rd, stall_id);
    end
    exp_bubbles += 2;
`ifdef STALL_COUNTER_EN
    n_total++;
    if (bubble_count !== exp_bubbles)
      $display("FAIL load_use_bubbles got=%0d exp=%0d", bubble_count, exp_bubbles);
    else n_pass++;
`endif
  endtask

  task automatic test_flush();
    steps.delete();
    // Flush at N: bubbles at N+1, N+2, real instruction at N+3.
    steps.push_back(st(X, 1'b1, 1'b1, 1'b1, 1'b0, ex_t'(0)));
    steps.push_back(st(Y, 1'b0, 1'b1, 1'b1, 1'b0, ex_t'(0)));
    steps.push_back(st(Y, 1'b0, 1'b1, 1'b1, 1'b0, adv(Y)));
    // A second flush inside FLUSH reloads the counter.
    steps.push_back(st(X, 1'b1, 1'b1, 1'b1, 1'b0, ex_t'(0)));
    steps.push_back(st(Y, 1'b1, 1'b1, 1'b1, 1'b0, ex_t'(0)));
    steps.push_back(st(Y, 1'b0, 1'b1, 1'b1, 1'b0, ex_t'(0)));
    steps.push_back(st(Y, 1'b0, 1'b1, 1'b1, 1'b0, adv(Y)));
    foreach (steps[k]) begin
      id_drv = steps[k].id; flush = steps[k].flush; ex_ready = steps[k].ready; rst_n = steps[k].rst_n;
      #1;
      n_total++;
      if (stall_id !== steps[k].stall)
        $display("FAIL flush_stall step=%0d got=%b exp=%b", k, stall_id, steps[k].stall);
      else n_pass++;
      sb.push_back(steps[k].exp);
      @(posedge clk); #1;
      exp_item = sb.pop_front();
      n_total++;
      if (w_got !== exp_item)
        $display("FAIL flush_ex step=%0d got=%h exp=%h", k, w_got, exp_item);
      else n_pass++;
      $display("flush     step %0d: ex_valid=%b pc=%h rd=%0d stall=%b", k, ex_valid, ex_pc, ex_rd, stall_id);
    end
    exp_bubbles += 5;
`ifdef STALL_COUNTER_EN
    n_total++;
    if (bubble_count !== exp_bubbles)
      $display("FAIL flush_bubbles got=%0d exp=%0d", bubble_count, exp_bubbles);
    else n_pass++;
`endif
  endtask

  task automatic test_back_pressure();
    steps.delete();
    steps.push_back(st(P,   1'b0, 1'b1, 1'b1, 1'b0, adv(P)));
    steps.push_back(st(Q,   1'b0, 1'b0, 1'b1, 1'b1, adv(P)));
    steps.push_back(st(Q,   1'b0, 1'b0, 1'b1, 1'b1, adv(P)));
    steps.push_back(st(Q,   1'b0, 1'b0, 1'b1, 1'b1, adv(P)));
    steps.push_back(st(Q,   1'b0, 1'b1, 1'b1, 1'b0, adv(Q)));
    // Flush while EX is stalled still squashes.
    steps.push_back(st(P,   1'b1, 1'b0, 1'b1, 1'b0, ex_t'(0)));
    steps.push_back(st(Q,   1'b0, 1'b1, 1'b1, 1'b0, ex_t'(0)));
    steps.push_back(st(Q,   1'b0, 1'b1, 1'b1, 1'b0, adv(Q)));
    // Back-pressure outranks a load-use hazard: hold, no bubble.
    steps.push_back(st(LWH, 1'b0, 1'b1, 1'b1, 1'b0, adv(LWH)));
    steps.push_back(st(H,   1'b0, 1'b0, 1'b1, 1'b1, adv(LWH)));
    steps.push_back(st(H,   1'b0, 1'b1, 1'b1, 1'b1, ex_t'(0)));
    steps.push_back(st(H,   1'b0, 1'b1, 1'b1, 1'b0, adv(H)));
    foreach (steps[k]) begin
      id_drv = steps[k].id; flush = steps[k].flush; ex_ready = steps[k].ready; rst_n = steps[k].rst_n;
      #1;
      n_total++;
      if (stall_id !== steps[k].stall)
        $display("FAIL backpress_stall step=%0d got=%b exp=%b", k, stall_id, steps[k].stall);
      else n_pass++;
      sb.push_back(steps[k].exp);
      @(posedge clk); #1;
      exp_item = sb.pop_front();
      n_total++;
      if (w_got !== exp_item)
        $display("FAIL backpress_ex step=%0d got=%h exp=%h", k, w_got, exp_item);
      else n_pass++;
      $display("backpress step %0d: ex_valid=%b pc=%h rd=%0d stall=%b", k, ex_valid, ex_pc, ex_rd, stall_id);
    end
    exp_bubbles += 3;
`ifdef STALL_COUNTER_EN
    n_total++;
    if (bubble_count !== exp_bubbles)
      $display("FAIL backpress_bubbles got=%0d exp=%0d", bubble_count, exp_bubbles);
    else n_pass++;
`endif
  endtask

  task automatic test_simultaneous();
    steps.delete();
    // Flush together with a load-use hazard: flush wins, no LOAD_STALL.
    steps.push_back(st(LW5, 1'b0, 1'b1, 1'b1, 1'b0, adv(LW5)));
    steps.push_back(st(ADD, 1'b1, 1'b1, 1'b1, 1'b0, ex_t'(0)));
    steps.push_back(st(ADD, 1'b0, 1'b1, 1'b1, 1'b0, ex_t'(0)));
    steps.push_back(st(ADD, 1'b0, 1'b1, 1'b1, 1'b0, adv(ADD)));
    // Reset in the middle of FLUSH returns straight to RUN.
    steps.push_back(st(X,   1'b1, 1'b1, 1'b1, 1'b0, ex_t'(0)));
    steps.push_back(st(X,   1'b1, 1'b1, 1'b0, 1'b0, ex_t'(0)));
    steps.push_back(st(Y,   1'b0, 1'b1, 1'b1, 1'b0, adv(Y)));
    foreach (steps[k]) begin
      id_drv = steps[k].id; flush = steps[k].flush; ex_ready = steps[k].ready; rst_n = steps[k].rst_n;
      #1;
      n_total++;
      if (stall_id !== steps[k].stall)
        $display("FAIL simult_stall step=%0d got=%b exp=%b", k, stall_id, steps[k].stall);
      else n_pass++;
      sb.push_back(steps[k].exp);
      @(posedge clk); #1;
      exp_item = sb.pop_front();
      n_total++;
      if (w_got !== exp_item)
        $display("FAIL simult_ex step=%0d got=%h exp=%h", k, w_got, exp_item);
      else n_pass++;
      $display("simult    step %0d: ex_valid=%b pc=%h rd=%0d stall=%b", k, ex_valid, ex_pc, ex_rd, stall_id);
    end
    exp_bubbles = 0;
`ifdef STALL_COUNTER_EN
    n_total++;
    if (bubble_count !== exp_bubbles)
      $display("FAIL simult_bubbles got=%0d exp=%0d", bubble_count, exp_bubbles);
    else n_pass++;
`endif
  endtask

  initial begin
    n_pass      = 0;
    n_total     = 0;
    exp_bubbles = 0;
    IDLE = '0;
    A    = mk(32'h100, 5'd1,  5'd2,  5'd5,  1'b1, 1'b1, 1'b1, 1'b0, FORWARD_IMM);
    C    = mk(32'h104, 5'd7,  5'd8,  5'd31, 1'b1, 1'b0, 1'b1, 1'b0, 2'b01);
    LW5  = mk(32'h200, 5'd2,  5'd0,  5'd5,  1'b1, 1'b0, 1'b1, 1'b1, FORWARD_NONE);
    ADD  = mk(32'h204, 5'd5,  5'd1,  5'd6,  1'b1, 1'b1, 1'b1, 1'b0, 2'b01);
    LW0  = mk(32'h300, 5'd3,  5'd0,  5'd0,  1'b1, 1'b0, 1'b1, 1'b1, FORWARD_NONE);
    ADD0 = mk(32'h304, 5'd0,  5'd4,  5'd7,  1'b1, 1'b1, 1'b1, 1'b0, 2'b01);
    LW7  = mk(32'h400, 5'd1,  5'd0,  5'd7,  1'b1, 1'b0, 1'b1, 1'b1, FORWARD_NONE);
    SUB  = mk(32'h404, 5'd2,  5'd7,  5'd8,  1'b1, 1'b1, 1'b1, 1'b0, 2'b01);
    LW9  = mk(32'h500, 5'd1,  5'd0,  5'd9,  1'b1, 1'b0, 1'b1, 1'b1, FORWARD_NONE);
    NU   = mk(32'h504, 5'd9,  5'd9,  5'd10, 1'b0, 1'b0, 1'b1, 1'b0, FORWARD_IMM);
    X    = mk(32'h600, 5'd1,  5'd2,  5'd3,  1'b1, 1'b1, 1'b1, 1'b0, 2'b01);
    Y    = mk(32'h604, 5'd3,  5'd2,  5'd4,  1'b1, 1'b1, 1'b1, 1'b0, FORWARD_IMM);
    P    = mk(32'h700, 5'd1,  5'd2,  5'd11, 1'b1, 1'b1, 1'b1, 1'b0, 2'b11);
    Q    = mk(32'h704, 5'd4,  5'd5,  5'd12, 1'b1, 1'b1, 1'b1, 1'b0, 2'b01);
    LWH  = mk(32'h800, 5'd1,  5'd0,  5'd13, 1'b1, 1'b0, 1'b1, 1'b1, FORWARD_NONE);
    H    = mk(32'h804, 5'd13, 5'd2,  5'd14, 1'b1, 1'b0, 1'b1, 1'b0, 2'b01);

    // Initialise state so the combinational stall output is defined.
    rst_n    = 1'b0;
    flush    = 1'b0;
    ex_ready = 1'b1;
    id_drv   = A;
    @(posedge clk); #1;

    test_reset();
    test_advance();
    test_load_use();
    test_flush();
    test_back_pressure();
    test_simultaneous();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
